output_wormhole_arbiter: RTL and testbench
==========================================

// Module: output_wormhole_arbiter
// PURPOSE
//  Per-output-port scheduler of a RaveNoC router. Shares one output port among the N_INPUTS input routers requesting it.
//  Wormhole locking per VC: the input granted a HEAD flit owns that VC on the port until its TAIL flit transfers.
//  Strict VC priority: higher vc_id wins. A higher VC may preempt a locked lower VC mid-packet; the lower VC lock is retained.
//  Round-robin among inputs within one VC. Zero-latency combinational grant; lock/pointer state is sequential.
// PARAMETERS
//  N_INPUTS    4     number of requesting input routers (>=2)
//  N_VC        2     virtual channels; defaults to ravenoc_pkg::N_VIRT_CHN
//  WDOG_CYCLES 1024  watchdog stall threshold in cycles (used only with OUT_ARB_WDOG_EN)
// PORTS
//  clk         in   1                    clock
//  arst        in   1                    reset: synchronous, active-high (sampled on posedge clk only)
//  req_i       in   N_INPUTS             input i presents a flit for this port
//  vc_i        in   N_INPUTS*VC_W        VC of each request, VC_W=$clog2(N_VC)
//  head_i      in   N_INPUTS             flit is a HEAD
//  tail_i      in   N_INPUTS             flit is a TAIL (head_i&tail_i = single-flit packet)
//  ready_i     in   1                    downstream output buffer accepts the flit
//  grant_o     out  N_INPUTS             one-hot grant (or zero)
//  valid_o     out  1                    |grant_o
//  grant_vc_o  out  VC_W                 VC of the granted flit
//  locked_o    out  N_VC                 VC v currently owned by an input
//  wdog_err_o  out  N_VC                 sticky stall error per VC
// BEHAVIOUR
//  - fire = valid_o & ready_i. State changes only on fire, except the watchdog.
//  - Per-VC state: IDLE or LOCKED(owner_ff[v]); per-VC rr_ptr_ff[v].
//  - Candidate for VC v:
//    - LOCKED: only owner_ff[v], when req & vc==v.
//    - IDLE: round-robin from rr_ptr_ff[v] among inputs with req & vc==v & head_i.
//    - Non-head request on an IDLE VC: never granted.
//  - Select the highest v with a candidate. grant_o/grant_vc_o are combinational, same cycle.
//  - On fire at VC v:
//    - IDLE & head & !tail -> LOCKED, owner_ff <= granted idx.
//    - IDLE & head & tail -> stays IDLE.
//    - LOCKED & tail -> IDLE.
//    - A head fire sets rr_ptr_ff[v] <= (idx+1) mod N_INPUTS.
//  - ready_i low: grant may be shown; no state change; grant stays stable while inputs are unchanged.
//  - Preemption: a lower VC's LOCKED state and owner persist while a higher VC transfers. It resumes when the higher VC has no candidate.
//  - One transfer per cycle; simultaneous TAIL on VC1 and HEAD on VC0 means only the selected one fires.
//  - Reset: while arst=1, grant_o=0, valid_o=0, grant_vc_o=0, locked_o=0, wdog_err_o=0. Next cycle: all VCs IDLE, rr_ptr=0.
//  - Reset mid-packet drops all locks; no flit state is kept.
// CONFIGURATION
//  OUT_ARB_WDOG_EN defined:
//  - Per-VC counter increments while LOCKED and the owner has no matching req.
//  - Counter clears on owner req or on unlock; it saturates.
//  - On reaching WDOG_CYCLES, wdog_err_o[v] is set (sticky until reset).
//  OUT_ARB_WDOG_EN undefined: no counters, wdog_err_o tied to 0.
// STRUCTURE
//  - ravenoc_pkg: add typedef enum {ARB_IDLE, ARB_LOCKED} arb_st_t; typedef s_arb_vc_t {st, owner, rr_ptr}.
//  - ravenoc_pkg: use existing N_VIRT_CHN, HEAD/TAIL flit types.
//  - Sub-module rr_arbiter (N parameter): req, ptr -> one-hot grant. Instantiated once per VC.
//  - Top level: lock muxing, VC priority select, state registers, watchdog generate block.
// TESTING
//  1. Reset, then inputs 0..3 send single-flit HEAD+TAIL on VC0, ready=1, 4 cycles -> grants 0,1,2,3 in order; locked_o stays 0.
//  2. In0 HEAD on VC0, then in1 HEAD on VC0 -> in1 blocked until in0 TAIL fires; in1 granted the cycle after.
//  3. In0 mid-packet on VC0 (locked); in2 HEAD on VC1 -> VC1 granted; locked_o=2'b11.
//     After in2 TAIL, in0 resumes VC0 with no new head.
//  4. ready_i=0 for 5 cycles with in1 HEAD pending -> grant_o=0010 stable; no lock until the first ready cycle.
//  5. arst asserted while VC0 locked -> next cycle locked_o=0, rr_ptr=0.
//     Body flit from the old owner is not granted.
//  6. OUT_ARB_WDOG_EN, WDOG_CYCLES=8: lock VC0, drop owner req 8 cycles -> wdog_err_o[0]=1 stays set.
//     Undefined -> stays 0.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared NoC types: VC count, flit kinds, output-arbiter state
package ravenoc_pkg;

    // Number of virtual channels per physical link.
    localparam int N_VIRT_CHN = 2;

    // Width of the input-index fields kept in arbiter state (up to 16 inputs).
    localparam int ARB_IDX_W = 4;

    typedef enum logic [1:0] {
        HEAD_FLIT      = 2'd0,
        BODY_FLIT      = 2'd1,
        TAIL_FLIT      = 2'd2,
        HEAD_TAIL_FLIT = 2'd3
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_st_t;

    typedef struct packed {
        arb_st_t                st;
        logic [ARB_IDX_W-1:0]   owner;
        logic [ARB_IDX_W-1:0]   rr_ptr;
    } s_arb_vc_t;

    function automatic flit_type_t flit_kind(input logic head, input logic tail);
        flit_type_t k;
        case ({head, tail})
            2'b10:   k = HEAD_FLIT;
            2'b01:   k = TAIL_FLIT;
            2'b11:   k = HEAD_TAIL_FLIT;
            default: k = BODY_FLIT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a given pointer
//
// Ports:
//   req   [N-1:0]      requesting lines
//   ptr   [IDX_W-1:0]  highest-priority index this cycle (must be < N)
//   grant [N-1:0]      one-hot grant, zero when no request
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int idx;

    // Walk offsets from farthest to nearest so the last hit, i.e. the
    // request closest to ptr, is the one left in grant.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_wormhole_arbiter.sv
// rtl/output_wormhole_arbiter.sv - per-output-port wormhole VC arbiter with strict VC priority
//
// Optional feature macro: OUT_ARB_WDOG_EN (per-VC stall watchdog).
//
// Ports:
//   clk         clock
//   arst        synchronous active-high reset
//   req_i       per-input flit request for this port
//   vc_i        per-input VC id, VC_W bits each, input i at [i*VC_W +: VC_W]
//   head_i      per-input HEAD marker
//   tail_i      per-input TAIL marker (head&tail = single-flit packet)
//   ready_i     downstream accepts a flit this cycle
//   grant_o     one-hot grant (combinational)
//   valid_o     any grant
//   grant_vc_o  VC of the granted flit
//   locked_o    per-VC wormhole lock held
//   wdog_err_o  per-VC sticky stall error (zero when OUT_ARB_WDOG_EN undefined)
module output_wormhole_arbiter
    import ravenoc_pkg::*;
#(
    parameter  int N_INPUTS    = 4,
    parameter  int N_VC        = N_VIRT_CHN,
    parameter  int WDOG_CYCLES = 1024,
    localparam int VC_W        = (N_VC > 1) ? $clog2(N_VC) : 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_INPUTS-1:0]      req_i,
    input  logic [N_INPUTS*VC_W-1:0] vc_i,
    input  logic [N_INPUTS-1:0]      head_i,
    input  logic [N_INPUTS-1:0]      tail_i,
    input  logic                     ready_i,
    output logic [N_INPUTS-1:0]      grant_o,
    output logic                     valid_o,
    output logic [VC_W-1:0]          grant_vc_o,
    output logic [N_VC-1:0]          locked_o,
    output logic [N_VC-1:0]          wdog_err_o
);

    if (N_INPUTS < 2 || N_INPUTS > (1 << ARB_IDX_W) || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("output_wormhole_arbiter: unsupported parameter set");
    end

    s_arb_vc_t st_q [N_VC];
    s_arb_vc_t st_d [N_VC];

    logic [N_INPUTS-1:0] vc_match [N_VC];
    logic [N_INPUTS-1:0] head_req [N_VC];
    logic [N_INPUTS-1:0] rr_gnt   [N_VC];
    logic [N_INPUTS-1:0] owner_oh [N_VC];
    logic [N_INPUTS-1:0] cand     [N_VC];

    logic [N_INPUTS-1:0]  sel_gnt;
    logic [VC_W-1:0]      sel_vc;
    logic [ARB_IDX_W-1:0] gidx;
    logic                 fire;
    logic                 sel_head;
    logic                 sel_tail;

    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                vc_match[v][i] = req_i[i] && (vc_i[i*VC_W +: VC_W] == VC_W'(v));
            end
            head_req[v] = vc_match[v] & head_i;
            owner_oh[v] = N_INPUTS'(1) << st_q[v].owner;
        end
    end

    for (genvar v = 0; v < N_VC; v++) begin : g_rr
        rr_arbiter #(
            .N     (N_INPUTS),
            .IDX_W (ARB_IDX_W)
        ) u_rr (
            .req   (head_req[v]),
            .ptr   (st_q[v].rr_ptr),
            .grant (rr_gnt[v])
        );
    end

    // A locked VC only serves its owner (any flit kind); an idle VC only
    // accepts new packets, so stray body/tail flits there are ignored.
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            if (st_q[v].st == ARB_LOCKED) begin
                cand[v] = vc_match[v] & owner_oh[v];
            end else begin
                cand[v] = rr_gnt[v];
            end
        end
    end

    // Ascending scan: the highest VC with a candidate overwrites lower ones.
    always_comb begin
        sel_gnt = '0;
        sel_vc  = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (|cand[v]) begin
                sel_gnt = cand[v];
                sel_vc  = VC_W'(v);
            end
        end
        gidx = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel_gnt[i]) begin
                gidx = ARB_IDX_W'(i);
            end
        end
    end

    assign grant_o    = arst ? '0 : sel_gnt;
    assign grant_vc_o = arst ? '0 : sel_vc;
    assign valid_o    = |grant_o;
    assign fire       = valid_o & ready_i;
    assign sel_head   = |(sel_gnt & head_i);
    assign sel_tail   = |(sel_gnt & tail_i);

    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            st_d[v] = st_q[v];
            if (fire && (sel_vc == VC_W'(v))) begin
                case (flit_kind(sel_head, sel_tail))
                    HEAD_FLIT: begin
                        if (st_q[v].st == ARB_IDLE) begin
                            st_d[v].st    = ARB_LOCKED;
                            st_d[v].owner = gidx;
                        end
                    end
                    TAIL_FLIT, HEAD_TAIL_FLIT: begin
                        st_d[v].st = ARB_IDLE;
                    end
                    default: ;
                endcase
                if (sel_head) begin
                    st_d[v].rr_ptr = (gidx == ARB_IDX_W'(N_INPUTS - 1)) ? '0 : gidx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < N_VC; v++) begin
                st_q[v] <= '{st: ARB_IDLE, owner: '0, rr_ptr: '0};
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                st_q[v] <= st_d[v];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            locked_o[v] = (st_q[v].st == ARB_LOCKED) && !arst;
        end
    end

`ifdef OUT_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q [N_VC];
    logic [WD_W-1:0] wd_cnt_d [N_VC];
    logic [N_VC-1:0] wd_err_q;
    logic [N_VC-1:0] wd_err_d;

    // Count cycles a locked VC's owner is absent; any owner request or an
    // unlock restarts the count. The count saturates at the threshold.
    always_comb begin
        wd_err_d = wd_err_q;
        for (int v = 0; v < N_VC; v++) begin
            wd_cnt_d[v] = '0;
            if ((st_q[v].st == ARB_LOCKED) && !(|(vc_match[v] & owner_oh[v]))) begin
                wd_cnt_d[v] = (wd_cnt_q[v] == WD_W'(WDOG_CYCLES)) ? wd_cnt_q[v]
                                                                  : wd_cnt_q[v] + 1'b1;
            end
            if (wd_cnt_d[v] == WD_W'(WDOG_CYCLES)) begin
                wd_err_d[v] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wd_err_q <= '0;
            for (int v = 0; v < N_VC; v++) begin
                wd_cnt_q[v] <= '0;
            end
        end else begin
            wd_err_q <= wd_err_d;
            for (int v = 0; v < N_VC; v++) begin
                wd_cnt_q[v] <= wd_cnt_d[v];
            end
        end
    end

    assign wdog_err_o = arst ? '0 : wd_err_q;
`else
    assign wdog_err_o = '0;
`endif

endmodule

// File: tb/tb_output_wormhole_arbiter.sv
// tb/tb_output_wormhole_arbiter.sv - directed self-checking bench for output_wormhole_arbiter
module tb_output_wormhole_arbiter;

`ifdef OUT_ARB_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req;
    logic [3:0] vc;
    logic [3:0] head;
    logic [3:0] tail;
    logic       ready;
    logic [3:0] grant_o;
    logic       valid_o;
    logic       grant_vc_o;
    logic [1:0] locked_o;
    logic [1:0] wdog_err_o;

    int errors = 0;
    int checks = 0;

    output_wormhole_arbiter #(
        .N_INPUTS    (4),
        .N_VC        (2),
        .WDOG_CYCLES (8)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_i      (req),
        .vc_i       (vc),
        .head_i     (head),
        .tail_i     (tail),
        .ready_i    (ready),
        .grant_o    (grant_o),
        .valid_o    (valid_o),
        .grant_vc_o (grant_vc_o),
        .locked_o   (locked_o),
        .wdog_err_o (wdog_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic gv, input logic [1:0] l);
        chk({tag, ".grant"},  8'(grant_o),    8'(g));
        chk({tag, ".valid"},  8'(valid_o),    8'(|g));
        chk({tag, ".vc"},     8'(grant_vc_o), 8'(gv));
        chk({tag, ".locked"}, 8'(locked_o),   8'(l));
    endtask

    task automatic idle_in();
        req  = '0;
        vc   = '0;
        head = '0;
        tail = '0;
    endtask

    task automatic flit(input int i, input logic v, input logic h, input logic t);
        req[i]  = 1'b1;
        vc[i]   = v;
        head[i] = h;
        tail[i] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: outputs forced low even with a head request present.
        arst  = 1'b1;
        ready = 1'b1;
        idle_in();
        flit(0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        #1 chk_out("reset", 4'b0000, 1'b0, 2'b00);
        chk("reset.wdog", 8'(wdog_err_o), 8'h00);
        idle_in();
        arst = 1'b0;
        tick();

        // 1: single-flit packets from all inputs rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) begin
            idle_in();
            for (int i = 0; i < 4; i++) flit(i, 1'b0, 1'b1, 1'b1);
            #1 chk_out($sformatf("t1_rr%0d", k), 4'(1 << k), 1'b0, 2'b00);
            tick();
        end

        // 2: in0 locks VC0; in1 head waits until in0 tail has fired.
        idle_in(); flit(0, 1'b0, 1'b1, 1'b0); flit(1, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t2_head", 4'b0001, 1'b0, 2'b00);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b0); flit(1, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t2_body", 4'b0001, 1'b0, 2'b01);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b1); flit(1, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t2_tail", 4'b0001, 1'b0, 2'b01);
        tick();
        idle_in(); flit(1, 1'b0, 1'b1, 1'b1);
        #1 chk_out("t2_next", 4'b0010, 1'b0, 2'b00);
        tick();

        // 3: VC1 preempts locked VC0; VC0 resumes without a new head.
        idle_in(); flit(0, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t3_lock0", 4'b0001, 1'b0, 2'b00);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b0); flit(2, 1'b1, 1'b1, 1'b0);
        #1 chk_out("t3_vc1head", 4'b0100, 1'b1, 2'b01);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b0); flit(2, 1'b1, 1'b0, 1'b1);
        #1 chk_out("t3_vc1tail", 4'b0100, 1'b1, 2'b11);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_resume", 4'b0001, 1'b0, 2'b01);
        tick();
        idle_in(); flit(0, 1'b0, 1'b0, 1'b1);
        #1 chk_out("t3_tail0", 4'b0001, 1'b0, 2'b01);
        tick();

        // 4: backpressure holds a stable grant and defers the lock.
        idle_in(); ready = 1'b0; flit(1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1 chk_out($sformatf("t4_stall%0d", k), 4'b0010, 1'b0, 2'b00);
            tick();
        end
        ready = 1'b1;
        #1 chk_out("t4_ready", 4'b0010, 1'b0, 2'b00);
        tick();
        idle_in(); flit(1, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t4_locked", 4'b0010, 1'b0, 2'b01);

        // 5: reset mid-packet drops the lock and the round-robin pointer.
        arst = 1'b1;
        #1 chk_out("t5_inrst", 4'b0000, 1'b0, 2'b00);
        tick();
        arst = 1'b0;
        #1 chk_out("t5_body", 4'b0000, 1'b0, 2'b00);
        idle_in(); flit(0, 1'b0, 1'b1, 1'b1); flit(2, 1'b0, 1'b1, 1'b1);
        #1 chk_out("t5_ptr0", 4'b0001, 1'b0, 2'b00);
        tick();

        // 6: owner of locked VC0 goes silent.
        idle_in(); flit(0, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t6_lock", 4'b0001, 1'b0, 2'b00);
        tick();
        idle_in();
        for (int k = 0; k < 7; k++) tick();
        #1 chk("t6_wdog7", 8'(wdog_err_o), 8'h00);
        tick();
        #1 chk("t6_wdog8", 8'(wdog_err_o), WD_EN ? 8'h01 : 8'h00);
        for (int k = 0; k < 3; k++) tick();
        #1 chk("t6_wdog11", 8'(wdog_err_o), WD_EN ? 8'h01 : 8'h00);
        chk_out("t6_still", 4'b0000, 1'b0, 2'b01);
        flit(0, 1'b0, 1'b0, 1'b1);
        #1 chk_out("t6_tail", 4'b0001, 1'b0, 2'b01);
        tick();
        idle_in();
        #1 chk_out("t6_unlock", 4'b0000, 1'b0, 2'b00);
        chk("t6_sticky", 8'(wdog_err_o), WD_EN ? 8'h01 : 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
